// File: rtl/camera_capture_ctrl.sv
// camera_capture_ctrl
// Frame-synchronised capture controller. It waits for a clean vsync frame
// boundary (low, then high), then crops incoming pixels to an
// FB_WIDTH x FB_HEIGHT window and turns them into framebuffer writes with one
// cycle of latency. The end of a frame is checked for an exact pixel count.
// Single-shot and continuous (re-arming) modes are supported. A stop request
// lets the current frame finish. A timeout bounds each vsync wait.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_stop     capture / stop request pulses
//   i_continuous        re-arm after each frame (latched on accepted start)
//   i_vsync             camera vsync, high during the frame
//   i_pix_*             pixel strobe, RGB565 data, row and column
//   o_wr_en/addr/data   framebuffer write port (registered)
//   o_busy              controller not idle
//   o_frame_done        one-cycle pulse per completed frame
//   o_frame_count       completed frames since reset (wraps)
//   o_timeout           one-cycle pulse when a vsync wait expires
//   o_error             sticky: short/long frame or timeout
module camera_capture_ctrl #(
  parameter int unsigned FB_WIDTH    = 320,
  parameter int unsigned FB_HEIGHT   = 240,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_continuous,
  input  logic              i_vsync,
  input  logic              i_pix_valid,
  input  logic [15:0]       i_pix_data,
  input  logic [9:0]        i_pix_row,
  input  logic [9:0]        i_pix_col,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [7:0]        o_frame_count,
  output logic              o_timeout,
  output logic              o_error
);

  localparam int unsigned NPIX  = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned CNT_W = $clog2(NPIX + 2);
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] PIX_FULL = CNT_W'(NPIX);
  localparam logic [CNT_W-1:0] PIX_SAT  = CNT_W'(NPIX + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SYNC_LOW  = 2'd1,
    ST_SYNC_HIGH = 2'd2,
    ST_CAPTURE   = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic             continuous_r;
  logic             stop_pend_r;
  logic [CNT_W-1:0] pix_cnt_r;
  logic [TMO_W-1:0] tmo_cnt_r;

  logic in_window_s;
  logic start_s;
  logic accept_s;
  logic frame_end_s;
  logic timeout_s;
  logic sync_next_s;

  assign in_window_s = i_pix_valid
                     && (32'(i_pix_row) < FB_HEIGHT)
                     && (32'(i_pix_col) < FB_WIDTH);
  assign sync_next_s = (state_s == ST_SYNC_LOW) || (state_s == ST_SYNC_HIGH);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_s     = state_r;
    start_s     = 1'b0;
    accept_s    = 1'b0;
    frame_end_s = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Stop has priority over a simultaneous start.
        if (i_start && !i_stop) begin
          state_s = ST_SYNC_LOW;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SYNC_LOW: begin
        // Wait for the frame boundary so a frame is never entered mid-way.
        if (i_stop) begin
          state_s = ST_IDLE;
        end else if (!i_vsync) begin
          state_s = ST_SYNC_HIGH;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_s   = ST_IDLE;
          timeout_s = 1'b1;
        end else begin
          state_s = ST_SYNC_LOW;
        end
      end
      ST_SYNC_HIGH: begin
        if (i_stop) begin
          state_s = ST_IDLE;
        end else if (i_vsync) begin
          state_s = ST_CAPTURE;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_s   = ST_IDLE;
          timeout_s = 1'b1;
        end else begin
          state_s = ST_SYNC_HIGH;
        end
      end
      ST_CAPTURE: begin
        if (!i_vsync) begin
          frame_end_s = 1'b1;
          // A stop arriving on the frame-end cycle also ends the run.
          if (continuous_r && !stop_pend_r && !i_stop) begin
            state_s = ST_SYNC_HIGH;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s  = ST_CAPTURE;
          accept_s = in_window_s;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Mode, stop-pending, pixel and timeout counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      continuous_r <= 1'b0;
      stop_pend_r  <= 1'b0;
      pix_cnt_r    <= '0;
      tmo_cnt_r    <= '0;
    end else begin
      if (start_s) begin
        continuous_r <= i_continuous;
      end
      if (state_s == ST_IDLE) begin
        stop_pend_r <= 1'b0;
      end else if ((state_r == ST_CAPTURE) && i_stop) begin
        stop_pend_r <= 1'b1;
      end
      if (start_s || ((state_r == ST_SYNC_HIGH) && (state_s == ST_CAPTURE))) begin
        pix_cnt_r <= '0;
      end else if (accept_s && (pix_cnt_r != PIX_SAT)) begin
        pix_cnt_r <= pix_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      // Restart the wait budget on every entry into a sync state.
      if (sync_next_s && (state_s != state_r)) begin
        tmo_cnt_r <= '0;
      end else if ((state_r == ST_SYNC_LOW) || (state_r == ST_SYNC_HIGH)) begin
        tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Registered outputs: write port, status pulses, frame count and error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wr_en       <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= 16'h0000;
      o_busy        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_count <= 8'd0;
      o_timeout     <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      o_wr_en      <= accept_s;
      o_busy       <= (state_s != ST_IDLE);
      o_frame_done <= frame_end_s;
      o_timeout    <= timeout_s;
      if (accept_s) begin
        o_wr_addr <= ADDR_W'(32'(i_pix_row) * FB_WIDTH + 32'(i_pix_col));
        o_wr_data <= i_pix_data;
      end
      if (frame_end_s) begin
        o_frame_count <= o_frame_count + 8'd1;
      end
      if (start_s) begin
        o_error <= 1'b0;
      end else if (timeout_s || (frame_end_s && (pix_cnt_r != PIX_FULL))) begin
        o_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_camera_capture_ctrl.sv
module tb_camera_capture_ctrl;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int T  = 50;
  localparam int AW = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_rst, i_start, i_stop, i_continuous, i_vsync, i_pix_valid;
  logic [15:0]   i_pix_data;
  logic [9:0]    i_pix_row, i_pix_col;
  logic          o_wr_en, o_busy, o_frame_done, o_timeout, o_error;
  logic [AW-1:0] o_wr_addr;
  logic [15:0]   o_wr_data;
  logic [7:0]    o_frame_count;

  camera_capture_ctrl #(.FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_W(AW), .TIMEOUT_CYC(T)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
    .i_continuous(i_continuous), .i_vsync(i_vsync), .i_pix_valid(i_pix_valid),
    .i_pix_data(i_pix_data), .i_pix_row(i_pix_row), .i_pix_col(i_pix_col),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_frame_count(o_frame_count),
    .o_timeout(o_timeout), .o_error(o_error)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [AW-1:0] addr; logic [15:0] data; } wr_t;
  typedef struct packed { logic [7:0] cnt; logic err; } fd_t;
  wr_t wr_q[$];
  fd_t fd_q[$];
  wr_t mon_w;
  fd_t mon_f;
  logic prev_done = 1'b0;
  logic prev_tmo  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop expected writes / frame completions whenever the DUT presents them.
  always @(negedge clk) begin
    if (o_wr_en) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", o_wr_addr, o_wr_data);
      end else begin
        mon_w = wr_q.pop_front();
        chk("wr_addr", 32'(o_wr_addr), 32'(mon_w.addr));
        chk("wr_data", 32'(o_wr_data), 32'(mon_w.data));
      end
    end
    if (o_frame_done) begin
      chk("frame_done_single_cycle", 32'(prev_done), 32'd0);
      if (fd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame_done: count %0d, none expected", o_frame_count);
      end else begin
        mon_f = fd_q.pop_front();
        chk("frame_count", 32'(o_frame_count), 32'(mon_f.cnt));
        chk("frame_error", 32'(o_error), 32'(mon_f.err));
      end
    end
    if (o_timeout) begin
      chk("timeout_single_cycle", 32'(prev_tmo), 32'd0);
    end
    prev_done = o_frame_done;
    prev_tmo  = o_timeout;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int r, input int c, input logic [15:0] d, input bit exp_w);
    i_pix_valid = 1'b1;
    i_pix_row   = 10'(r);
    i_pix_col   = 10'(c);
    i_pix_data  = d;
    if (exp_w) wr_q.push_back('{addr: AW'(r * W + c), data: d});
    tick();
    i_pix_valid = 1'b0;
  endtask

  task automatic start(input logic cont);
    i_continuous = cont;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Raise vsync (enter CAPTURE) and send a full in-window frame.
  task automatic frame8(input logic [15:0] base);
    i_vsync = 1'b1;
    tick();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        pix(r, c, base + 16'(r * W + c), 1'b1);
  endtask

  task automatic frame_end(input logic [7:0] cnt, input logic err);
    fd_q.push_back('{cnt: cnt, err: err});
    i_vsync = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(o_wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(o_wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(o_wr_data), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(o_frame_done), 32'd0);
    chk({tag, "_frame_count"}, 32'(o_frame_count), 32'd0);
    chk({tag, "_timeout"}, 32'(o_timeout), 32'd0);
    chk({tag, "_error"}, 32'(o_error), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_continuous = 1'b0;
    i_vsync = 1'b0; i_pix_valid = 1'b0; i_pix_data = 16'h0000;
    i_pix_row = 10'd0; i_pix_col = 10'd0;
    tick(); tick();
    i_rst = 1'b0;
    check_all_zero("reset");

    // Single-shot frame, addresses 0..7.
    start(1'b0);
    tick();
    frame8(16'hA000);
    frame_end(8'd1, 1'b0);
    chk("t1_busy", 32'(o_busy), 32'd0);
    chk("t1_count", 32'(o_frame_count), 32'd1);
    chk("t1_error", 32'(o_error), 32'd0);

    // Start mid-frame: nothing written until vsync low then high.
    i_vsync = 1'b1;
    start(1'b0);
    for (int k = 0; k < 4; k++) pix(0, k, 16'hDEAD, 1'b0);
    i_vsync = 1'b0;
    tick();
    pix(1, 1, 16'hBEEF, 1'b0);
    frame8(16'h2000);
    frame_end(8'd2, 1'b0);
    chk("t2_error", 32'(o_error), 32'd0);

    // Out-of-window pixels dropped; short frame flags error.
    start(1'b0);
    tick();
    i_vsync = 1'b1;
    tick();
    pix(0, 0, 16'h3000, 1'b1);
    pix(0, 5, 16'h3FFF, 1'b0);
    pix(0, 1, 16'h3001, 1'b1);
    pix(2, 1, 16'h3EEE, 1'b0);
    pix(0, 2, 16'h3002, 1'b1);
    pix(1, 0, 16'h3004, 1'b1);
    pix(1, 3, 16'h3007, 1'b1);
    pix(0, 3, 16'h3003, 1'b1);
    frame_end(8'd3, 1'b1);
    chk("t3_error", 32'(o_error), 32'd1);

    // Vsync held low: timeout 50 cycles after entering SYNC_HIGH.
    i_vsync = 1'b0;
    start(1'b0);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (o_timeout) begin n = k; break; end
    end
    chk("timeout_latency", 32'(n), 32'd51);
    chk("timeout_error", 32'(o_error), 32'd1);
    chk("timeout_busy", 32'(o_busy), 32'd0);
    start(1'b0);
    chk("restart_clears_error", 32'(o_error), 32'd0);
    chk("restart_busy", 32'(o_busy), 32'd1);
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    chk("stop_in_sync_busy", 32'(o_busy), 32'd0);
    i_start = 1'b1; i_stop = 1'b1;
    tick();
    i_start = 1'b0; i_stop = 1'b0;
    chk("start_stop_busy", 32'(o_busy), 32'd0);

    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("reset2_count", 32'(o_frame_count), 32'd0);

    // Continuous mode, stop during frame 3.
    start(1'b1);
    tick();
    frame8(16'h4000);
    frame_end(8'd1, 1'b0);
    chk("cont_busy_f1", 32'(o_busy), 32'd1);
    frame8(16'h5000);
    frame_end(8'd2, 1'b0);
    chk("cont_busy_f2", 32'(o_busy), 32'd1);
    i_vsync = 1'b1;
    tick();
    for (int k = 0; k < W * H; k++) begin
      i_stop = (k == 3);
      pix(k / W, k % W, 16'h6000 + 16'(k), 1'b1);
      i_stop = 1'b0;
    end
    frame_end(8'd3, 1'b0);
    chk("cont_stop_busy", 32'(o_busy), 32'd0);
    chk("cont_count", 32'(o_frame_count), 32'd3);
    i_vsync = 1'b1; tick(); tick();
    i_vsync = 1'b0; tick(); tick();
    chk("cont_stays_idle", 32'(o_busy), 32'd0);

    // Reset in the middle of CAPTURE.
    start(1'b0);
    tick();
    i_vsync = 1'b1;
    tick();
    pix(0, 0, 16'h7000, 1'b1);
    pix(0, 1, 16'h7001, 1'b1);
    pix(0, 2, 16'h7002, 1'b1);
    i_rst = 1'b1;
    i_pix_valid = 1'b1; i_pix_row = 10'd0; i_pix_col = 10'd3; i_pix_data = 16'h7003;
    tick();
    i_rst = 1'b0;
    i_pix_valid = 1'b0;
    check_all_zero("midrst");
    i_vsync = 1'b0;
    tick(); tick(); tick();
    chk("midrst_idle", 32'(o_busy), 32'd0);

    tick(); tick();
    chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    chk("fd_queue_drained", 32'(fd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
